cpu_ram_ctl: RTL

Parametrised single-port synchronous RAM for the 6502 system bus. It replaces the fixed 512-byte data RAM and adds configurable width and depth, an automatic clear-on-reset sequence with a CPU ready handshake, and a write-protected address window with a sticky violation flag. It sits on the CPU address/data bus beside ROM and I/O and is selected by the external address decoder through `CS`.

---
 rtl/cpu_ram_ctl_if.sv | 26 ++
 rtl/cpu_ram_ctl.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu_ram_ctl_if.sv
// CPU-side bus bundle for cpu_ram_ctl.
// DO_EN mirrors the tri-state enable of DO so the driven/Z state is observable.
interface cpu_ram_ctl_if #(
    parameter int DW = 8,
    parameter int AW = 9
);
    logic [AW-1:0] AB;
    logic [DW-1:0] DI;
    logic [DW-1:0] DO;
    logic          DO_EN;
    logic          CS;
    logic          WE;
    logic          WP_EN;
    logic          RDY;
    logic          WPERR;

    modport master (
        output AB, DI, CS, WE, WP_EN,
        input  DO, DO_EN, RDY, WPERR
    );

    modport slave (
        input  AB, DI, CS, WE, WP_EN,
        output DO, DO_EN, RDY, WPERR
    );
endinterface

// File: rtl/cpu_ram_ctl.sv
// Single-port synchronous RAM for the 6502 bus with clear-on-reset
// sequence, CPU ready handshake and write-protected address window.
module cpu_ram_ctl #(
    parameter int          DW             = 8,
    parameter int          AW             = 9,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned CLEAR_VAL      = 0,
    parameter int unsigned WP_LO          = 0,
    parameter int unsigned WP_HI          = 0
) (
    input  logic         clk,
    input  logic         reset,
    cpu_ram_ctl_if.slave bus
);
    localparam int              DEPTH   = 2 ** AW;
    localparam logic [DW-1:0]   CV      = DW'(CLEAR_VAL);
    localparam bit              WP_ON   = (WP_LO <= WP_HI);
    localparam int unsigned     WP_SPAN = WP_HI - WP_LO;

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam state_t S_INIT = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_rdy;
    logic          r_err;
    logic          r_oe;
    logic [DW-1:0] r_rd;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_run;
    logic          w_rd;
    logic          w_wr;
    logic          w_prot;
    logic [31:0]   w_off;
    logic          w_we;
    logic [AW-1:0] w_wa;
    logic [DW-1:0] w_wd;

    assign w_run  = (r_state == S_RUN);
    assign w_rd   = bus.CS && !bus.WE && w_run;
    assign w_wr   = bus.CS && bus.WE && w_run;
    // Offset compare handles the inclusive window without a constant bound check
    assign w_off  = 32'(bus.AB) - WP_LO;
    assign w_prot = WP_ON && bus.WP_EN && (w_off <= WP_SPAN);

    always_comb begin
        w_we = 1'b0;
        w_wa = bus.AB;
        w_wd = bus.DI;
        if (!reset) begin
            if (!w_run) begin
                w_we = 1'b1;
                w_wa = r_cnt;
                w_wd = CV;
            end else if (w_wr && !w_prot) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wa] <= w_wd;
        if (w_rd) r_rd <= r_mem[bus.AB];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            r_oe <= w_rd && !reset;
            unique case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= S_RUN;
                        r_rdy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_rdy <= 1'b1;
                    if (w_wr && w_prot) r_err <= 1'b1;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.DO    = r_oe ? r_rd : {DW{1'bz}};
    assign bus.DO_EN = r_oe;
    assign bus.RDY   = r_rdy;
    assign bus.WPERR = r_err;
endmodule
